// File: rtl/axi_lite_bram_pkg.sv
// axi_lite_bram_pkg: response codes and FSM state encodings shared by the AXI-Lite BRAM bridge
package axi_lite_bram_pkg;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RSP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RSP} r_state_t;
endpackage

// File: rtl/axi_lite_bram_arb.sv
// axi_lite_bram_arb: round-robin arbiter between the write and read FSMs, write favoured after reset
module axi_lite_bram_arb
  import axi_lite_bram_pkg::*;
(
  input  logic s_axi_aclk,
  input  logic s_axi_aresetn,
  input  logic req_w,
  input  logic req_r,
  output logic gnt_w,
  output logic gnt_r
);
  logic prio_w;
  assign gnt_w = req_w && (!req_r || prio_w);
  assign gnt_r = req_r && (!req_w || !prio_w);
  // priority passes to the losing side only when both sides compete
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) prio_w <= 1'b1;
    else if (req_w && req_r) prio_w <= !prio_w;
endmodule

// File: rtl/axi_lite_bram_bridge.sv
// axi_lite_bram_bridge: AXI4-Lite slave to single-port BRAM; define AXI_LITE_BRAM_ADDR_CHECK_EN to reject addresses >= MEM_BYTES with SLVERR
module axi_lite_bram_bridge
  import axi_lite_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_wr_data,
  input  logic [DATA_WIDTH-1:0]   bram_rd_data,
  output logic                    bram_en,
  output logic [DATA_WIDTH/8-1:0] bram_we,
  output logic                    bram_re
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int SH = $clog2(SW);

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || RD_LATENCY < 1 || RD_LATENCY > 4 || MEM_BYTES < 1) begin : g_bad_cfg
    $error("axi_lite_bram_bridge: illegal parameter set");
  end

  w_state_t              w_state;
  r_state_t              r_state;
  logic                  aw_got, w_got, aw_have, w_have;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [SW-1:0]         wstrb;
  logic [1:0]            cnt;
  logic                  gnt_w, gnt_r, werr, rerr, acc_w, acc_r;

  assign aw_have = aw_got || (s_axi_awvalid && s_axi_awready);
  assign w_have  = w_got || (s_axi_wvalid && s_axi_wready);

`ifdef AXI_LITE_BRAM_ADDR_CHECK_EN
  assign werr = waddr >= ADDR_WIDTH'(MEM_BYTES);
  assign rerr = raddr >= ADDR_WIDTH'(MEM_BYTES);
`else
  assign werr = 1'b0;
  assign rerr = 1'b0;
`endif

  axi_lite_bram_arb u_arb (
    .s_axi_aclk   (s_axi_aclk),
    .s_axi_aresetn(s_axi_aresetn),
    .req_w        (w_state == W_REQ),
    .req_r        (r_state == R_REQ),
    .gnt_w        (gnt_w),
    .gnt_r        (gnt_r)
  );

  // BRAM is driven only in the granted cycle; empty strobes and rejected addresses skip the access
  assign acc_w        = gnt_w && |wstrb && !werr;
  assign acc_r        = gnt_r && !rerr;
  assign bram_en      = acc_w || acc_r;
  assign bram_re      = acc_r;
  assign bram_we      = acc_w ? wstrb : '0;
  assign bram_wr_data = acc_w ? wdata : '0;
  assign bram_addr    = acc_w ? waddr >> SH : acc_r ? raddr >> SH : '0;

  // write FSM: collect AW and W in any order, request one access, then hold the response until bready
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      w_state       <= W_IDLE;
      aw_got        <= 1'b0;
      w_got         <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= OKAY;
      waddr         <= '0;
      wdata         <= '0;
      wstrb         <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid && s_axi_awready) waddr <= s_axi_awaddr;
          if (s_axi_wvalid && s_axi_wready) begin
            wdata <= s_axi_wdata;
            wstrb <= s_axi_wstrb;
          end
          aw_got        <= aw_have && !w_have;
          w_got         <= w_have && !aw_have;
          s_axi_awready <= !aw_have;
          s_axi_wready  <= !w_have;
          if (aw_have && w_have) w_state <= W_REQ;
        end
        W_REQ:
          if (gnt_w) begin
            w_state      <= W_RSP;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= werr ? SLVERR : OKAY;
          end
        W_RSP:
          if (s_axi_bready) begin
            w_state       <= W_IDLE;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= OKAY;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
          end
        default: w_state <= W_IDLE;
      endcase
    end

  // read FSM: capture AR, request one access, wait out the BRAM latency, hold data until rready
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= OKAY;
      s_axi_rdata   <= '0;
      raddr         <= '0;
      cnt           <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= !(s_axi_arvalid && s_axi_arready);
          if (s_axi_arvalid && s_axi_arready) begin
            raddr   <= s_axi_araddr;
            r_state <= R_REQ;
          end
        end
        R_REQ:
          if (gnt_r) begin
            r_state <= R_WAIT;
            cnt     <= '0;
          end
        R_WAIT:
          if (cnt == 2'(RD_LATENCY - 1)) begin
            r_state      <= R_RSP;
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rerr ? '0 : bram_rd_data;
            s_axi_rresp  <= rerr ? SLVERR : OKAY;
          end else cnt <= cnt + 2'd1;
        R_RSP:
          if (s_axi_rready) begin
            r_state       <= R_IDLE;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= OKAY;
            s_axi_arready <= 1'b1;
          end
        default: r_state <= R_IDLE;
      endcase
    end
endmodule
